wscs_engine: RTL and testbench
==============================

Name: wscs_engine

Overview:
Parametrised weighted-sum checksum engine for the packet buffer RAM. On a start pulse it walks a payload of payload_len words from base_addr. It accumulates each word times a cyclic power-of-two weight (1,2,4,...,2^(WEIGHT_STAGES-1), then repeat). It then either appends the checksum after the payload (generate mode) or reads the stored trailer and compares it (check mode). It sits between the packet assembler and the TX/RX framers and shares the single-port synchronous RAM with them.

Parameters:
RAM_WIDTH, 8, word width of buffer RAM
RAM_ADDR_BITS, 11, RAM address width; all addresses wrap modulo 2^RAM_ADDR_BITS
SUM_WIDTH, 16, checksum width; must be an integer multiple of RAM_WIDTH (TRAILER_WORDS = SUM_WIDTH/RAM_WIDTH)
WEIGHT_STAGES, 4, length of weight cycle, 1..8
LEN_BITS, 16, width of payload_len

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = generate/append, 1 = check; latched with start
base_addr  in  RAM_ADDR_BITS  first payload address; latched with start
payload_len  in  LEN_BITS  payload length in words; latched with start
mem_ready  in  1  RAM arbitration grant; engine must not drive RAM cycles while low
address  out  RAM_ADDR_BITS  RAM address
write_enable  out  1  RAM write strobe
mem_input  out  RAM_WIDTH  RAM write data
mem_output  in  RAM_WIDTH  RAM read data, valid one cycle after address
busy  out  1  high from the cycle after an accepted start until work_complete
work_complete  out  1  one-cycle done pulse
check_ok  out  1  check result; valid from work_complete until next accepted start
sum_out  out  SUM_WIDTH  final checksum; valid with work_complete, held until next start

Behaviour:
- Reset (async): all outputs 0, state IDLE, accumulator 0, weight index 0. Reset mid-operation aborts the run immediately and issues no further writes. A write in flight is cut when write_enable drops.
- States: IDLE, WAIT_MEM, RD_ADDR, RD_DATA, TR_SETUP, TR_WRITE, TR_ADDR, TR_DATA, DONE.
- IDLE: on start=1, latch mode, base_addr, payload_len; clear accumulator, weight index and word counter; go to WAIT_MEM. start while busy is ignored.
- WAIT_MEM: stay while mem_ready=0. When it is 1, go to RD_ADDR, or straight to the trailer phase if payload_len=0.
- RD_ADDR: address = base_addr + count (mod 2^RAM_ADDR_BITS); go to RD_DATA.
- RD_DATA: acc <= acc + (zero-extended mem_output << weight_index), truncated to SUM_WIDTH (mod 2^SUM_WIDTH). Weight index increments and wraps to 0 at WEIGHT_STAGES. count++. If count reaches payload_len, go to the trailer phase; else go to RD_ADDR.
- Read phase costs exactly 2 cycles per word.
- If mem_ready drops during the read phase, finish the current RD_DATA, then pause in WAIT_MEM. Resume at the current count.
- Trailer address for word k (k=0 most significant) = base_addr + payload_len + k, mod 2^RAM_ADDR_BITS.
- Generate mode: for each k, TR_SETUP drives address and mem_input = checksum word k with write_enable=0. TR_WRITE holds both and drives write_enable=1 for exactly one cycle. Trailer is written big-endian.
- Check mode: for each k, TR_ADDR then TR_DATA compares mem_output with word k. Any mismatch clears an internal match flag, which is set at start.
- DONE: pulse work_complete=1 for one cycle, drop busy, and present sum_out. check_ok = match flag in check mode, 0 in generate mode. Return to IDLE.
- A start asserted in the same cycle as work_complete is ignored. A start in the following cycle is accepted.
- write_enable is never high in any state other than TR_WRITE.

Test Plan:
1. Generate mode, base 0x000, len 5, RAM 01 02 03 04 05 -> sum 1+4+12+32+5 = 0x0036. Writes 0x00@0x005 then 0x36@0x006. work_complete 1 cycle, sum_out=0x0036, check_ok=0.
2. Check mode on the buffer from test 1 -> check_ok=1, no write_enable pulses. Corrupt 0x006 to 0x37 and repeat -> check_ok=0, sum_out still 0x0036.
3. Eight words of 0xFF, generate -> sum 2*15*255 = 0x1DE2, trailer 0x1D,0xE2. Then a long payload whose sum exceeds 0xFFFF -> sum_out equals the reference model value mod 2^16.
4. Wrap: base 0x7FE, len 4 -> reads 0x7FE,0x7FF,0x000,0x001; trailer written at 0x002,0x003. len 0 -> writes 0x00,0x00 at base, sum_out=0.
5. mem_ready low at start for 5 cycles, then toggled low mid-read -> no RAM address change while paused, same final sum as an uninterrupted run. start pulses while busy -> ignored.
6. Assert reset asynchronously between TR_SETUP and TR_WRITE -> all outputs 0 within the reset, no write_enable pulse. A later start runs cleanly.

Source files
------------

// File: rtl/wscs_engine.sv
// Weighted-sum checksum engine: walks a payload in the shared buffer RAM, then
// appends the checksum as a big-endian trailer or verifies the stored one.
module wscs_engine #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 11,
  parameter int SUM_WIDTH     = 16,
  parameter int WEIGHT_STAGES = 4,
  parameter int LEN_BITS      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]      payload_len,
  input  logic                     mem_ready,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic                     write_enable,
  output logic [RAM_WIDTH-1:0]     mem_input,
  input  logic [RAM_WIDTH-1:0]     mem_output,
  output logic                     busy,
  output logic                     work_complete,
  output logic                     check_ok,
  output logic [SUM_WIDTH-1:0]     sum_out
);

  localparam int TRAILER_WORDS = SUM_WIDTH / RAM_WIDTH;
  localparam int WI_BITS = (WEIGHT_STAGES > 1) ? $clog2(WEIGHT_STAGES) : 1;
  localparam int K_BITS  = (TRAILER_WORDS > 1) ? $clog2(TRAILER_WORDS) : 1;

  typedef enum logic [3:0] {
    IDLE, WAIT_MEM, RD_ADDR, RD_DATA, TR_SETUP, TR_WRITE, TR_ADDR, TR_DATA, DONE
  } state_t;

  state_t                   state, state_next;
  logic                     mode_q;
  logic [RAM_ADDR_BITS-1:0] base_q;
  logic [LEN_BITS-1:0]      len_q;
  logic [LEN_BITS-1:0]      count;
  logic [SUM_WIDTH-1:0]     acc;
  logic [WI_BITS-1:0]       widx;
  logic [K_BITS-1:0]        k;
  logic                     match;

  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic [RAM_ADDR_BITS-1:0] tr_addr;
  logic [SUM_WIDTH-1:0]     acc_shift;
  logic [RAM_WIDTH-1:0]     tr_word;
  logic                     word_match;
  logic                     last_word;
  logic                     last_tr;
  state_t                   tr_first;

  assign rd_addr    = base_q + RAM_ADDR_BITS'(count);
  assign tr_addr    = base_q + RAM_ADDR_BITS'(len_q) + RAM_ADDR_BITS'(k);
  // Trailer word 0 is the most significant slice of the checksum.
  assign acc_shift  = acc >> ((TRAILER_WORDS - 1 - int'(k)) * RAM_WIDTH);
  assign tr_word    = acc_shift[RAM_WIDTH-1:0];
  assign word_match = (mem_output == tr_word);
  assign last_word  = ((count + LEN_BITS'(1)) == len_q);
  assign last_tr    = (k == K_BITS'(TRAILER_WORDS - 1));
  assign tr_first   = mode_q ? TR_ADDR : TR_SETUP;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = WAIT_MEM;
      WAIT_MEM: if (mem_ready) state_next = (count == len_q) ? tr_first : RD_ADDR;
      RD_ADDR:  state_next = RD_DATA;
      RD_DATA: begin
        if (last_word)      state_next = tr_first;
        else if (mem_ready) state_next = RD_ADDR;
        else                state_next = WAIT_MEM;
      end
      TR_SETUP: if (mem_ready) state_next = TR_WRITE;
      TR_WRITE: state_next = last_tr ? DONE : TR_SETUP;
      TR_ADDR:  if (mem_ready) state_next = TR_DATA;
      TR_DATA:  state_next = last_tr ? DONE : TR_ADDR;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    address       = '0;
    write_enable  = 1'b0;
    mem_input     = '0;
    busy          = (state != IDLE) && (state != DONE);
    work_complete = (state == DONE);
    case (state)
      WAIT_MEM, RD_ADDR, RD_DATA: address = rd_addr;
      TR_SETUP: begin
        address   = tr_addr;
        mem_input = tr_word;
      end
      TR_WRITE: begin
        address      = tr_addr;
        mem_input    = tr_word;
        write_enable = 1'b1;
      end
      TR_ADDR, TR_DATA: address = tr_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      count    <= '0;
      acc      <= '0;
      widx     <= '0;
      k        <= '0;
      match    <= 1'b0;
      sum_out  <= '0;
      check_ok <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          mode_q   <= mode;
          base_q   <= base_addr;
          len_q    <= payload_len;
          count    <= '0;
          acc      <= '0;
          widx     <= '0;
          k        <= '0;
          match    <= 1'b1;
          sum_out  <= '0;
          check_ok <= 1'b0;
        end
        RD_DATA: begin
          acc   <= acc + (SUM_WIDTH'(mem_output) << widx);
          widx  <= (widx == WI_BITS'(WEIGHT_STAGES - 1)) ? '0 : widx + WI_BITS'(1);
          count <= count + LEN_BITS'(1);
        end
        TR_WRITE: k <= k + K_BITS'(1);
        TR_DATA: begin
          if (!word_match) match <= 1'b0;
          k <= k + K_BITS'(1);
        end
        default: ;
      endcase
      // Results are captured on entry to DONE so the last trailer compare is included.
      if (state_next == DONE && state != DONE) begin
        sum_out  <= acc;
        check_ok <= mode_q & match & word_match;
      end
    end
  end

endmodule

// File: tb/tb_wscs_engine.sv
// Directed bench for wscs_engine with a behavioural single-port synchronous RAM.
module tb_wscs_engine;

  logic        clock = 1'b0;
  logic        reset, start, mode, mem_ready;
  logic [10:0] base_addr, address;
  logic [15:0] payload_len, sum_out;
  logic        write_enable, busy, work_complete, check_ok;
  logic [7:0]  mem_input, mem_output;

  logic [7:0]  ram [0:2047];
  int          wr_n = 0;
  logic [10:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  wscs_engine #(
    .RAM_WIDTH(8), .RAM_ADDR_BITS(11), .SUM_WIDTH(16), .WEIGHT_STAGES(4), .LEN_BITS(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .payload_len(payload_len), .mem_ready(mem_ready),
    .address(address), .write_enable(write_enable), .mem_input(mem_input),
    .mem_output(mem_output), .busy(busy), .work_complete(work_complete),
    .check_ok(check_ok), .sum_out(sum_out)
  );

  always @(posedge clock) begin
    if (write_enable) begin
      ram[address] <= mem_input;
      if (wr_n < 64) begin
        wr_addr[wr_n] = address;
        wr_data[wr_n] = mem_input;
      end
      wr_n = wr_n + 1;
    end
    mem_output <= ram[address];
  end

  typedef struct {
    int          fill;   // 0 keep, 1 ascending 1.., 2 all 0xFF, 3 corrupt trailer word 1
    logic        m;
    logic [10:0] b;
    logic [15:0] l;
    logic [15:0] sum;
    logic        ok;
    int          nwr;
    logic [10:0] a0;
    logic [7:0]  d0;
    logic [10:0] a1;
    logic [7:0]  d1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill(input int code, input logic [10:0] b, input logic [15:0] l);
    logic [10:0] a;
    for (int j = 0; j < int'(l); j++) begin
      a = b + 11'(j);
      if (code == 1) ram[a] <= 8'(j + 1);
      if (code == 2) ram[a] <= 8'hFF;
      if (code == 4) ram[a] <= 8'((j * 37 + 5) & 255);
    end
    if (code == 3) begin
      a = b + 11'(l) + 11'd1;
      ram[a] <= ram[a] ^ 8'h01;
    end
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (work_complete !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_timeout"}, {31'b0, work_complete !== 1'b1}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic m, input logic [10:0] b,
                        input logic [15:0] l);
    @(negedge clock);
    mode = m; base_addr = b; payload_len = l; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(name);
  endtask

  function automatic logic [15:0] model_sum(input logic [10:0] b, input int l);
    logic [31:0] s = 0;
    for (int j = 0; j < l; j++) s = s + (32'(ram[b + 11'(j)]) << (j % 4));
    return s[15:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    vec_t        v;
    int          w0;
    logic [10:0] held;
    logic        ok;
    logic [15:0] exp;
    int          n;

    for (int i = 0; i < 2048; i++) ram[i] <= 8'h00;
    reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; payload_len = '0; mem_ready = 1'b1;

    vecs[0] = '{1, 1'b0, 11'h000, 16'd5, 16'h0036, 1'b0, 2, 11'h005, 8'h00, 11'h006, 8'h36};
    vecs[1] = '{0, 1'b1, 11'h000, 16'd5, 16'h0036, 1'b1, 0, 11'h000, 8'h00, 11'h000, 8'h00};
    vecs[2] = '{3, 1'b1, 11'h000, 16'd5, 16'h0036, 1'b0, 0, 11'h000, 8'h00, 11'h000, 8'h00};
    vecs[3] = '{2, 1'b0, 11'h100, 16'd8, 16'h1DE2, 1'b0, 2, 11'h108, 8'h1D, 11'h109, 8'hE2};
    vecs[4] = '{0, 1'b1, 11'h100, 16'd8, 16'h1DE2, 1'b1, 0, 11'h000, 8'h00, 11'h000, 8'h00};
    vecs[5] = '{1, 1'b0, 11'h7FE, 16'd4, 16'h0031, 1'b0, 2, 11'h002, 8'h00, 11'h003, 8'h31};
    vecs[6] = '{0, 1'b0, 11'h200, 16'd0, 16'h0000, 1'b0, 2, 11'h200, 8'h00, 11'h201, 8'h00};
    vecs[7] = '{0, 1'b1, 11'h200, 16'd0, 16'h0000, 1'b1, 0, 11'h000, 8'h00, 11'h000, 8'h00};

    repeat (2) @(negedge clock);
    chk("reset_outputs", {address, write_enable, mem_input, busy, work_complete, check_ok, sum_out},
        32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      fill(v.fill, v.b, v.l);
      w0 = wr_n;
      run_op($sformatf("v%0d", i), v.m, v.b, v.l);
      chk($sformatf("v%0d_sum", i), 32'(sum_out), 32'(v.sum));
      chk($sformatf("v%0d_check_ok", i), 32'(check_ok), 32'(v.ok));
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(negedge clock);
      chk($sformatf("v%0d_done_pulse", i), 32'(work_complete), 32'd0);
      chk($sformatf("v%0d_sum_held", i), 32'(sum_out), 32'(v.sum));
      chk($sformatf("v%0d_writes", i), 32'(wr_n - w0), 32'(v.nwr));
      if (v.nwr == 2 && wr_n - w0 == 2) begin
        chk($sformatf("v%0d_wr0", i), {13'b0, wr_addr[w0], wr_data[w0]}, {13'b0, v.a0, v.d0});
        chk($sformatf("v%0d_wr1", i), {13'b0, wr_addr[w0+1], wr_data[w0+1]}, {13'b0, v.a1, v.d1});
      end
    end

    // Long payload: accumulator wraps modulo 2^16.
    fill(4, 11'h300, 16'd600);
    exp = model_sum(11'h300, 600);
    w0 = wr_n;
    run_op("long", 1'b0, 11'h300, 16'd600);
    chk("long_sum", 32'(sum_out), 32'(exp));
    if (wr_n - w0 == 2) begin
      chk("long_wr0", {13'b0, wr_addr[w0], wr_data[w0]}, {13'b0, 11'h558, exp[15:8]});
      chk("long_wr1", {13'b0, wr_addr[w0+1], wr_data[w0+1]}, {13'b0, 11'h559, exp[7:0]});
    end else chk("long_writes", 32'(wr_n - w0), 32'd2);

    // Stall at start, pause mid-read, and ignored start pulses while busy.
    fill(1, 11'h400, 16'd5);
    w0 = wr_n;
    mem_ready = 1'b0;
    @(negedge clock);
    mode = 1'b0; base_addr = 11'h400; payload_len = 16'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    held = address;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin start = 1'b1; mode = 1'b1; base_addr = 11'h123; payload_len = 16'd2; end
      if (c == 2) start = 1'b0;
      @(negedge clock);
      if (address !== held || busy !== 1'b1 || write_enable !== 1'b0) ok = 1'b0;
    end
    chk("stall_addr_base", 32'(held), 32'h400);
    chk("stall_stable", 32'(ok), 32'd1);
    mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    held = address;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (address !== held || busy !== 1'b1 || work_complete !== 1'b0) ok = 1'b0;
    end
    chk("pause_stable", 32'(ok), 32'd1);
    mem_ready = 1'b1;
    wait_done("pause");
    chk("pause_sum", 32'(sum_out), 32'h0036);
    chk("pause_check_ok", 32'(check_ok), 32'd0);
    if (wr_n - w0 == 2) begin
      chk("pause_wr0", {13'b0, wr_addr[w0], wr_data[w0]}, {13'b0, 11'h405, 8'h00});
      chk("pause_wr1", {13'b0, wr_addr[w0+1], wr_data[w0+1]}, {13'b0, 11'h406, 8'h36});
    end else chk("pause_writes", 32'(wr_n - w0), 32'd2);

    // Asynchronous reset while the first trailer word is being set up.
    fill(1, 11'h500, 16'd2);
    w0 = wr_n;
    @(negedge clock);
    mode = 1'b0; base_addr = 11'h500; payload_len = 16'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (address !== 11'h502 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("tr_setup_reached", 32'(address), 32'h502);
    chk("tr_setup_no_we", 32'(write_enable), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {address, write_enable, mem_input, busy, work_complete, check_ok, sum_out}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_no_write", 32'(wr_n - w0), 32'd0);
    w0 = wr_n;
    run_op("after_reset", 1'b0, 11'h500, 16'd2);
    chk("after_reset_sum", 32'(sum_out), 32'h0005);
    if (wr_n - w0 == 2) begin
      chk("after_reset_wr0", {13'b0, wr_addr[w0], wr_data[w0]}, {13'b0, 11'h502, 8'h00});
      chk("after_reset_wr1", {13'b0, wr_addr[w0+1], wr_data[w0+1]}, {13'b0, 11'h503, 8'h05});
    end else chk("after_reset_writes", 32'(wr_n - w0), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
